// File: rtl/game_match_fsm.sv
// Match controller for the two-player choice game: start, select, resolve, check, winner.
// Optional select-phase timeout is enabled by defining GAME_TIMEOUT_EN.
module game_match_fsm #(
  parameter int NUM_CHOICES    = 3,
  parameter int CHOICE_W       = 4,
  parameter int WIN_SCORE      = 3,
  parameter int ROUND_W        = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                restart,
  input  logic                p1_valid,
  input  logic [CHOICE_W-1:0] p1_choice,
  input  logic                p2_valid,
  input  logic [CHOICE_W-1:0] p2_choice,
  output logic [2:0]          state_o,
  output logic                p1_locked,
  output logic                p2_locked,
  output logic                result_valid,
  output logic [1:0]          round_result,
  output logic [3:0]          p1_score,
  output logic [3:0]          p2_score,
  output logic [ROUND_W-1:0]  round_count,
  output logic                winner
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    RESOLVE = 3'd2,
    CHECK   = 3'd3,
    WIN     = 3'd4
  } state_t;

  localparam logic [CHOICE_W:0] NUM_C = (CHOICE_W+1)'(NUM_CHOICES);
  localparam logic [3:0]        WIN_C = 4'(WIN_SCORE);

  // Arithmetic dominance: odd distance from P2's choice to P1's means P1 wins.
  function automatic logic [1:0] round_outcome(input logic [CHOICE_W-1:0] c1,
                                               input logic [CHOICE_W-1:0] c2);
    logic [CHOICE_W:0] d;
    if (c1 >= c2) begin
      d = {1'b0, c1} - {1'b0, c2};
    end else begin
      d = {1'b0, c1} + NUM_C - {1'b0, c2};
    end
    if (d == {(CHOICE_W+1){1'b0}}) begin
      round_outcome = 2'd0;
    end else if (d[0]) begin
      round_outcome = 2'd1;
    end else begin
      round_outcome = 2'd2;
    end
  endfunction

  // A missing lock forfeits the round to the player who did lock.
  function automatic logic [1:0] lock_outcome(input logic l1, input logic l2,
                                              input logic [CHOICE_W-1:0] c1,
                                              input logic [CHOICE_W-1:0] c2);
    if (l1 && l2) begin
      lock_outcome = round_outcome(c1, c2);
    end else if (l1) begin
      lock_outcome = 2'd1;
    end else if (l2) begin
      lock_outcome = 2'd2;
    end else begin
      lock_outcome = 2'd0;
    end
  endfunction

  state_t                state_r, state_nxt_s;
  logic [CHOICE_W-1:0]   p1_choice_r, p1_choice_nxt_s, p2_choice_r, p2_choice_nxt_s;
  logic                  p1_locked_r, p1_locked_nxt_s, p2_locked_r, p2_locked_nxt_s;
  logic                  result_valid_r, result_valid_nxt_s;
  logic [1:0]            round_result_r, round_result_nxt_s;
  logic [3:0]            p1_score_r, p1_score_nxt_s, p2_score_r, p2_score_nxt_s;
  logic [ROUND_W-1:0]    round_count_r, round_count_nxt_s;
  logic                  winner_r, winner_nxt_s;
  logic                  p1_take_s, p2_take_s, resolve_now_s;
`ifdef GAME_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]      tmo_cnt_r, tmo_cnt_nxt_s;
`endif

  // Next-state and next-register computation for the whole controller.
  always_comb begin
    state_nxt_s        = state_r;
    p1_choice_nxt_s    = p1_choice_r;
    p2_choice_nxt_s    = p2_choice_r;
    p1_locked_nxt_s    = p1_locked_r;
    p2_locked_nxt_s    = p2_locked_r;
    result_valid_nxt_s = 1'b0;
    round_result_nxt_s = round_result_r;
    p1_score_nxt_s     = p1_score_r;
    p2_score_nxt_s     = p2_score_r;
    round_count_nxt_s  = round_count_r;
    winner_nxt_s       = winner_r;
    resolve_now_s      = 1'b0;
    p1_take_s = (state_r == SELECT) && p1_valid && !p1_locked_r && ({1'b0, p1_choice} < NUM_C);
    p2_take_s = (state_r == SELECT) && p2_valid && !p2_locked_r && ({1'b0, p2_choice} < NUM_C);

    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s        = SELECT;
          p1_locked_nxt_s    = 1'b0;
          p2_locked_nxt_s    = 1'b0;
          round_result_nxt_s = 2'd0;
          p1_score_nxt_s     = 4'd0;
          p2_score_nxt_s     = 4'd0;
          round_count_nxt_s  = {ROUND_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SELECT: begin
        p1_locked_nxt_s = p1_locked_r | p1_take_s;
        p2_locked_nxt_s = p2_locked_r | p2_take_s;
        p1_choice_nxt_s = p1_take_s ? p1_choice : p1_choice_r;
        p2_choice_nxt_s = p2_take_s ? p2_choice : p2_choice_r;
        if (p1_locked_r && p2_locked_r) begin
          resolve_now_s = 1'b1;
        end else begin
`ifdef GAME_TIMEOUT_EN
          resolve_now_s = (tmo_cnt_r == TMO_LAST);
`else
          resolve_now_s = 1'b0;
`endif
        end
        if (resolve_now_s) begin
          state_nxt_s        = RESOLVE;
          result_valid_nxt_s = 1'b1;
          round_result_nxt_s = lock_outcome(p1_locked_nxt_s, p2_locked_nxt_s,
                                            p1_choice_nxt_s, p2_choice_nxt_s);
        end else begin
          state_nxt_s = SELECT;
        end
      end
      RESOLVE: begin
        state_nxt_s     = CHECK;
        p1_locked_nxt_s = 1'b0;
        p2_locked_nxt_s = 1'b0;
        case (round_result_r)
          2'd1:    p1_score_nxt_s = p1_score_r + 4'd1;
          2'd2:    p2_score_nxt_s = p2_score_r + 4'd1;
          default: p1_score_nxt_s = p1_score_r;
        endcase
        if (round_count_r != {ROUND_W{1'b1}}) begin
          round_count_nxt_s = round_count_r + ROUND_W'(1'b1);
        end else begin
          round_count_nxt_s = round_count_r;
        end
      end
      CHECK: begin
        if (p1_score_r == WIN_C) begin
          state_nxt_s  = WIN;
          winner_nxt_s = 1'b0;
        end else if (p2_score_r == WIN_C) begin
          state_nxt_s  = WIN;
          winner_nxt_s = 1'b1;
        end else begin
          state_nxt_s = SELECT;
        end
      end
      WIN: begin
        if (restart) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

`ifdef GAME_TIMEOUT_EN
    if ((state_r == SELECT) && !resolve_now_s) begin
      tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1'b1);
    end else begin
      tmo_cnt_nxt_s = {TMO_W{1'b0}};
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= IDLE;
      p1_choice_r    <= {CHOICE_W{1'b0}};
      p2_choice_r    <= {CHOICE_W{1'b0}};
      p1_locked_r    <= 1'b0;
      p2_locked_r    <= 1'b0;
      result_valid_r <= 1'b0;
      round_result_r <= 2'd0;
      p1_score_r     <= 4'd0;
      p2_score_r     <= 4'd0;
      round_count_r  <= {ROUND_W{1'b0}};
      winner_r       <= 1'b0;
`ifdef GAME_TIMEOUT_EN
      tmo_cnt_r      <= {TMO_W{1'b0}};
`endif
    end else begin
      state_r        <= state_nxt_s;
      p1_choice_r    <= p1_choice_nxt_s;
      p2_choice_r    <= p2_choice_nxt_s;
      p1_locked_r    <= p1_locked_nxt_s;
      p2_locked_r    <= p2_locked_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      round_result_r <= round_result_nxt_s;
      p1_score_r     <= p1_score_nxt_s;
      p2_score_r     <= p2_score_nxt_s;
      round_count_r  <= round_count_nxt_s;
      winner_r       <= winner_nxt_s;
`ifdef GAME_TIMEOUT_EN
      tmo_cnt_r      <= tmo_cnt_nxt_s;
`endif
    end
  end

  assign state_o      = state_r;
  assign p1_locked    = p1_locked_r;
  assign p2_locked    = p2_locked_r;
  assign result_valid = result_valid_r;
  assign round_result = round_result_r;
  assign p1_score     = p1_score_r;
  assign p2_score     = p2_score_r;
  assign round_count  = round_count_r;
  assign winner       = winner_r;

endmodule

// File: tb/tb_game_match_fsm.sv
// Bench for game_match_fsm: directed match scenarios plus random play, every cycle
// compared against a behavioural model of the game rules.
module tb_game_match_fsm;
  localparam int N   = 3;
  localparam int CW  = 4;
  localparam int WS  = 3;
  localparam int RW  = 3;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0, start = 1'b0, restart = 1'b0;
  logic          p1_valid = 1'b0, p2_valid = 1'b0;
  logic [CW-1:0] p1_choice = '0, p2_choice = '0;
  logic [2:0]    state_o;
  logic          p1_locked, p2_locked, result_valid, winner;
  logic [1:0]    round_result;
  logic [3:0]    p1_score, p2_score;
  logic [RW-1:0] round_count;

  int n_vec = 0, n_err = 0;
  // model of the match: phase codes 0..4 as listed for state_o
  int m_state = 0, m_l1 = 0, m_l2 = 0, m_c1 = 0, m_c2 = 0, m_rv = 0, m_rr = 0;
  int m_s1 = 0, m_s2 = 0, m_rc = 0, m_win = 0, m_sel = 0;

  always #5 clk = ~clk;

  game_match_fsm #(.NUM_CHOICES(N), .CHOICE_W(CW), .WIN_SCORE(WS), .ROUND_W(RW),
                   .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .restart(restart),
    .p1_valid(p1_valid), .p1_choice(p1_choice), .p2_valid(p2_valid), .p2_choice(p2_choice),
    .state_o(state_o), .p1_locked(p1_locked), .p2_locked(p2_locked),
    .result_valid(result_valid), .round_result(round_result),
    .p1_score(p1_score), .p2_score(p2_score), .round_count(round_count), .winner(winner));

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rule_outcome(input int a, input int b);
    int d;
    d = ((a - b) % N + N) % N;
    if (d == 0) return 0;
    return (d % 2 == 1) ? 1 : 2;
  endfunction

  task automatic model_step();
    int was_both, t1, t2;
    if (!reset) begin
      m_state = 0; m_l1 = 0; m_l2 = 0; m_c1 = 0; m_c2 = 0; m_rr = 0;
      m_s1 = 0; m_s2 = 0; m_rc = 0; m_win = 0; m_sel = 0; m_rv = 0;
      return;
    end
    case (m_state)
      0: if (start) begin
        m_state = 1; m_l1 = 0; m_l2 = 0; m_rr = 0; m_s1 = 0; m_s2 = 0; m_rc = 0; m_sel = 0;
      end
      1: begin
        was_both = m_l1 && m_l2;
        t1 = p1_valid && !m_l1 && (int'(p1_choice) < N);
        t2 = p2_valid && !m_l2 && (int'(p2_choice) < N);
        if (t1) begin m_l1 = 1; m_c1 = int'(p1_choice); end
        if (t2) begin m_l2 = 1; m_c2 = int'(p2_choice); end
        m_sel++;
        if (was_both) begin
          m_state = 2; m_rr = rule_outcome(m_c1, m_c2);
        end
`ifdef GAME_TIMEOUT_EN
        else if (m_sel == TMO) begin
          m_state = 2;
          m_rr = (m_l1 && m_l2) ? rule_outcome(m_c1, m_c2) : m_l1 ? 1 : m_l2 ? 2 : 0;
        end
`endif
      end
      2: begin
        if (m_rr == 1) m_s1++;
        if (m_rr == 2) m_s2++;
        m_rc = (m_rc + 1 > (1 << RW) - 1) ? (1 << RW) - 1 : m_rc + 1;
        m_l1 = 0; m_l2 = 0; m_state = 3;
      end
      3: begin
        if (m_s1 == WS) begin m_state = 4; m_win = 0; end
        else if (m_s2 == WS) begin m_state = 4; m_win = 1; end
        else begin m_state = 1; m_sel = 0; end
      end
      default: if (restart) m_state = 0;
    endcase
    m_rv = (m_state == 2);
  endtask

  task automatic compare_all();
    check_eq("state", int'(state_o), m_state);
    check_eq("p1_locked", int'(p1_locked), m_l1);
    check_eq("p2_locked", int'(p2_locked), m_l2);
    check_eq("result_valid", int'(result_valid), m_rv);
    check_eq("round_result", int'(round_result), m_rr);
    check_eq("p1_score", int'(p1_score), m_s1);
    check_eq("p2_score", int'(p2_score), m_s2);
    check_eq("round_count", int'(round_count), m_rc);
    check_eq("winner", int'(winner), m_win);
  endtask

  // one clock: drive at negedge, advance model at posedge, compare at next negedge
  task automatic tick(input bit rst, input bit st, input bit rs,
                      input bit v1, input int c1, input bit v2, input int c2);
    reset = rst; start = st; restart = rs;
    p1_valid = v1; p1_choice = CW'(c1); p2_valid = v2; p2_choice = CW'(c2);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int sel;
    @(negedge clk);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_state", int'(state_o), 0);
    tick(1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 1, 0, 0);
    check_eq("p1_lock_set", int'(p1_locked), 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    check_eq("midsel_rst_state", int'(state_o), 0);
    check_eq("midsel_rst_lock", int'(p1_locked), 0);
    check_eq("midsel_rst_score", int'(p1_score) + int'(p2_score), 0);

    tick(1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 1, 1, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("r1_valid", int'(result_valid), 1);
    check_eq("r1_result", int'(round_result), 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("r1_p1score", int'(p1_score), 1);
    check_eq("r1_rounds", int'(round_count), 1);
    tick(1, 0, 0, 0, 0, 0, 0);

    tick(1, 0, 0, 1, 2, 1, 2);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("tie_result", int'(round_result), 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("tie_p1score", int'(p1_score), 1);
    check_eq("tie_p2score", int'(p2_score), 0);
    check_eq("tie_rounds", int'(round_count), 2);
    tick(1, 0, 0, 0, 0, 0, 0);

    tick(1, 0, 0, 1, 3, 0, 0);
    check_eq("oor_nolock", int'(p1_locked), 0);
    tick(1, 0, 0, 1, 2, 0, 0);
    tick(1, 0, 0, 1, 0, 1, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("dup_result", int'(round_result), 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("dup_p1score", int'(p1_score), 2);
    tick(1, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      tick(1, 0, 0, 1, 0, 1, 1);
      tick(1, 0, 0, 0, 0, 0, 0);
      check_eq("p2_round_result", int'(round_result), 2);
      tick(1, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 0);
    end
    check_eq("win_state", int'(state_o), 4);
    check_eq("win_winner", int'(winner), 1);
    check_eq("win_p2score", int'(p2_score), 3);
    tick(1, 1, 0, 0, 0, 0, 0);
    check_eq("win_start_ignored", int'(state_o), 4);
    tick(1, 0, 1, 0, 0, 0, 0);
    check_eq("restart_idle", int'(state_o), 0);

`ifdef GAME_TIMEOUT_EN
    tick(1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 1);
    sel = 1;
    while (state_o == 3'd1 && sel < 40) begin
      tick(1, 0, 0, 0, 0, 0, 0);
      sel++;
    end
    check_eq("tmo_select_cycles", sel, TMO);
    check_eq("tmo_result", int'(round_result), 2);
`else
    sel = 0;
`endif

    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 300) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 3) == 0, $urandom_range(0, 4),
           ($urandom % 3) == 0, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
